// File: rtl/piso_pkg.sv
// Shared types and frame-length helper for the PISO serializer; PISO_PARITY_EN appends an even-parity bit.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-slot counter for one serial frame: counts 0..FL-1 while enabled, flags the final slot.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int FL    = 8,
  parameter int CNT_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(FL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, MSB first, gapless back-to-back frames.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the LSB.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof
);

  localparam int FL = frame_len(WIDTH, PARITY_EN);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             sout_q;
  logic             sout_d;
  logic             sout_valid_q;
  logic             sout_valid_d;
  logic             sof_q;
  logic             sof_d;
  logic             last_bit;
  logic             accept;
  logic             tail_bit;

  // The tail bit rides in the shift register behind the data, so the parity
  // slot falls out of the ordinary shift with no extra mux.
`ifdef PISO_PARITY_EN
  assign tail_bit = ^load_data;
`else
  assign tail_bit = 1'b0;
`endif

  piso_bit_counter #(
    .FL   (FL),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (accept || last_bit),
    .en_i  (state_q == ST_SHIFT),
    .last_o(last_bit)
  );

  always_comb begin
    load_ready   = !rst && ((state_q == ST_IDLE) || last_bit);
    accept       = load_valid && load_ready;
    state_d      = state_q;
    shift_d      = shift_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    sof_d        = 1'b0;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = ST_SHIFT;
      end
    end else if (last_bit && !accept) begin
      state_d = ST_IDLE;
    end

    if (accept) begin
      shift_d      = {load_data[WIDTH-2:0], tail_bit};
      sout_d       = load_data[WIDTH-1];
      sout_valid_d = 1'b1;
      sof_d        = 1'b1;
    end else if ((state_q == ST_SHIFT) && !last_bit) begin
      shift_d      = {shift_q[WIDTH-2:0], 1'b0};
      sout_d       = shift_q[WIDTH-1];
      sout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sof_q        <= sof_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sof        = sof_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer (WIDTH=8), default and PISO_PARITY_EN builds.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FLB = 9;
`else
  localparam int FLB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       sout;
  logic       sout_valid;
  logic       sof;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       rst;
    logic       lv;
    logic [7:0] ld;
    logic       rdy;
    logic       sout;
    logic       vld;
    logic       sof;
  } vec_t;

  vec_t tbl[$];

  piso_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sof       (sof)
  );

  always #5 clk = ~clk;

  function automatic void row(input logic r, input logic lv, input logic [7:0] ld,
                              input logic rdy, input logic so, input logic vld, input logic sf);
    vec_t v;
    v.rst = r; v.lv = lv; v.ld = ld; v.rdy = rdy; v.sout = so; v.vld = vld; v.sof = sf;
    tbl.push_back(v);
  endfunction

  // One frame's worth of cycles for word d with parity p; the source offers mid_ld
  // from slot mid_from onward and (last_lv, last_ld) in the final slot.
  function automatic void frame(input logic [7:0] d, input logic p, input int mid_from,
                                input logic [7:0] mid_ld, input logic last_lv,
                                input logic [7:0] last_ld);
    logic b;
    for (int i = 0; i < FLB; i++) begin
      b = (i < 8) ? d[7-i] : p;
      if (i == FLB - 1)
        row(1'b0, last_lv, last_ld, 1'b1, b, 1'b1, i == 0);
      else if (i >= mid_from)
        row(1'b0, 1'b1, mid_ld, 1'b0, b, 1'b1, i == 0);
      else
        row(1'b0, 1'b0, 8'hC3, 1'b0, b, 1'b1, i == 0);
    end
  endfunction

  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s row %0d: got %b expected %b", nm, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      n_pass++;
  endtask

  initial begin
    logic [15:0] word;
    int nb;
    int nsof;

    // Reset held with a word offered: nothing accepted, outputs quiet.
    for (int i = 0; i < 3; i++) row(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) row(1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    // Single word, then idle.
    row(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'hA5, 1'b0, 99, 8'h00, 1'b0, 8'hC3);
    for (int i = 0; i < 2; i++) row(1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    // Back-to-back FF then 00 with valid held.
    row(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'hFF, 1'b0, 0, 8'h00, 1'b1, 8'h00);
    frame(8'h00, 1'b0, 99, 8'h00, 1'b0, 8'hC3);
    row(1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    // Mid-frame hold-off of 3C until the last slot.
    row(1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h81, 1'b0, 1, 8'h3C, 1'b1, 8'h3C);
    frame(8'h3C, 1'b0, 99, 8'h00, 1'b0, 8'hC3);
    row(1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    // Reset at cycle 4 of A5 (with a word offered in the same cycle).
    row(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    row(1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1);
    row(1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    row(1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
    row(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) row(1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    // A5 then 07 back-to-back (parity 0 and 1 when enabled).
    row(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'hA5, 1'b0, 99, 8'h00, 1'b1, 8'h07);
    frame(8'h07, 1'b1, 99, 8'h00, 1'b0, 8'hC3);
    for (int i = 0; i < 2; i++) row(1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; load_valid = 1'b0; load_data = 8'h00;
    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      #1;
      rst = tbl[i].rst; load_valid = tbl[i].lv; load_data = tbl[i].ld;
      #1;
      chk("load_ready", i, load_ready, tbl[i].rdy);
      chk("sout", i, sout, tbl[i].sout);
      chk("sout_valid", i, sout_valid, tbl[i].vld);
      chk("sof", i, sof, tbl[i].sof);
      @(posedge clk);
    end

    // Single-cycle offer of 5A: collect the frame over a bounded window.
    #1;
    rst = 1'b0; load_valid = 1'b1; load_data = 8'h5A;
    #1;
    chk("hs_ready", 0, load_ready, 1'b1);
    @(posedge clk);
    #1;
    load_valid = 1'b0; load_data = 8'hC3;
    word = '0; nb = 0; nsof = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sout_valid) begin
        word = {word[14:0], sout};
        nb++;
        if (sof) nsof++;
        if (nb == 1) chk("hs_first_sof", c, sof, 1'b1);
      end
    end
    chk_int("hs_bits", nb, FLB);
    chk_int("hs_sofs", nsof, 1);
`ifdef PISO_PARITY_EN
    chk_int("hs_word", int'(word), int'({8'h5A, 1'b0}));
`else
    chk_int("hs_word", int'(word), 32'h5A);
`endif
    chk("hs_idle_ready", 1, load_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
